track_sensor_emulator: RTL

Stimulus-side counterpart of the train controller's sensor inputs. Models a train passing six track sensors in order and generates one registered pulse per sensor on S1..S6. Sensor-to-sensor spacing is programmable in clock cycles. The block drives the controller's synchronizer/time-measurement path in system benches and on-board demo mode.

---
 rtl/track_pkg.sv | 19 +
 rtl/segment_timer.sv | 45 ++++
 rtl/track_sensor_emulator.sv | 136 +++++++++++++
 3 files changed

// File: rtl/track_pkg.sv
// rtl/track_pkg.sv - shared constants, state codes and period helper for the track sensor emulator
package track_pkg;

   // Shared with the controller's sensor synchronizer.
   localparam int N_SENSORS = 6;
   localparam int PULSE_LEN = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_PULSE = 2'd1;
   localparam state_t ST_GAP   = 2'd2;

   // Spacing never drops below one pulse plus one low cycle, so seg_time=0 is legal.
   function automatic int unsigned eff_period(input int unsigned x, input int unsigned plen);
      return (x < plen + 1) ? plen + 1 : x;
   endfunction

endpackage

// File: rtl/segment_timer.sv
// rtl/segment_timer.sv - loadable saturating segment counter with pulse-end and segment-end compares
module segment_timer
   import track_pkg::*;
#(
   parameter int TW        = 19,
   parameter int PULSE_LEN = track_pkg::PULSE_LEN
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] period_in,
   output logic          pulse_end,
   output logic          seg_end
);

   logic [TW-1:0] count_q, count_d;
   logic [TW-1:0] period_q, period_d;

   // Count cycles since the pulse start; load restarts at zero and latches the new period.
   always_comb begin
      count_d  = (count_q == {TW{1'b1}}) ? count_q : count_q + TW'(1);
      period_d = period_q;
      if (load) begin
         count_d  = '0;
         period_d = period_in;
      end
   end

   // Counter and latched period registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         period_q <= '0;
      end else begin
         count_q  <= count_d;
         period_q <= period_d;
      end
   end

   // Both compares refer to the last cycle of their interval, so the next state lands on time.
   assign pulse_end = (count_q == TW'(PULSE_LEN - 1));
   assign seg_end   = (count_q == period_q - TW'(1));

endmodule

// File: rtl/track_sensor_emulator.sv
// rtl/track_sensor_emulator.sv - emulates a train passing six track sensors with programmable spacing
module track_sensor_emulator
   import track_pkg::*;
#(
   parameter int N_SENSORS = track_pkg::N_SENSORS,
   parameter int TW        = 19,
   parameter int PULSE_LEN = track_pkg::PULSE_LEN,
   parameter int LAPW      = 8
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 loop,
   input  logic [TW-1:0]        seg_time,
   output logic [N_SENSORS-1:0] s,
   output logic [2:0]           position,
   output logic                 busy,
   output logic                 done,
   output logic [LAPW-1:0]      lap_count
);

   state_t                 state_q, state_d;
   logic [N_SENSORS-1:0]   s_q, s_d;
   logic [2:0]             pos_q, pos_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [LAPW-1:0]        lap_q, lap_d;

   logic                   tmr_load;
   logic                   pulse_end;
   logic                   seg_end;
   logic [TW-1:0]          period_eff;

   assign period_eff = TW'(eff_period(32'(seg_time), 32'(PULSE_LEN)));

   segment_timer #(
      .TW        (TW),
      .PULSE_LEN (PULSE_LEN)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (tmr_load),
      .period_in (period_eff),
      .pulse_end (pulse_end),
      .seg_end   (seg_end)
   );

   // Run sequencing: abort overrides everything; each pulse start reloads the timer.
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      pos_d    = pos_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      lap_d    = lap_q;
      tmr_load = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         s_d     = '0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               s_d    = '0;
               busy_d = 1'b0;
               if (start) begin
                  pos_d    = '0;
                  s_d      = N_SENSORS'(1);
                  busy_d   = 1'b1;
                  tmr_load = 1'b1;
                  state_d  = ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (pulse_end) begin
                  s_d     = '0;
                  state_d = ST_GAP;
               end
            end
            ST_GAP: begin
               if (seg_end) begin
                  if (pos_q != 3'(N_SENSORS - 1)) begin
                     pos_d    = pos_q + 3'd1;
                     s_d      = N_SENSORS'(1) << (pos_q + 3'd1);
                     tmr_load = 1'b1;
                     state_d  = ST_PULSE;
                  end else if (loop) begin
                     pos_d    = '0;
                     lap_d    = lap_q + LAPW'(1);
                     s_d      = N_SENSORS'(1);
                     tmr_load = 1'b1;
                     state_d  = ST_PULSE;
                  end else begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
               s_d     = '0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // All outputs come straight from these registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         pos_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lap_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         pos_q   <= pos_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lap_q   <= lap_d;
      end
   end

   assign s         = s_q;
   assign position  = pos_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign lap_count = lap_q;

endmodule
